// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t     : FSM encoding (IDLE -> SHIFT -> DONE -> IDLE)
//   BCD_NIB     : bits per BCD digit
//   ADD3_THRESH : nibble value at or above which +3 correction applies
//   BLANK_NONE  : all-zero blank mask (slice to DIGITS bits at use site)
package bin2bcd_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          BCD_NIB     = 4;
  localparam int          ADD3_THRESH = 5;
  localparam logic [31:0] BLANK_NONE  = '0;
endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble nibble correction: dout = (din >= 5) ? din + 3 : din.
// Purely combinational; 4-bit result, no carry out (din <= 9 in practice,
// so din + 3 never exceeds 12).
//   din  : BCD nibble before shift
//   dout : corrected nibble
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_NIB-1:0] din,
  output logic [BCD_NIB-1:0] dout
);
  localparam logic [BCD_NIB-1:0] THRESH = ADD3_THRESH[BCD_NIB-1:0];

  always_comb begin
    dout = din;
    if (din >= THRESH) dout = din + BCD_NIB'(3);
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start in IDLE captures num; W clocks later bcd/blank update and done pulses
// for one cycle. Outputs hold between conversions, so a display never sees
// partial values.
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset
//   start : conversion request, sampled only in IDLE
//   num   : binary value, captured on the accepted start
//   busy  : high in SHIFT and DONE
//   done  : one-cycle pulse, bcd/blank just updated
//   bcd   : packed BCD, digit i at [4i+3:4i], digit 0 = units
//   blank : leading-zero blank mask, bit i blanks digit i
// Optional feature macro BIN2BCD_LZ_BLANK_EN: when defined, blank[i] (i >= 1)
// is set when digit i and all higher digits are zero; blank[0] is never set.
// When undefined, blank is constant zero and no blank logic exists.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [W-1:0]              num,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_NIB*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]         blank
);
  localparam int CW = $clog2(W + 1);
  localparam int BW = BCD_NIB * DIGITS;

  state_t          state_q, state_d;
  logic [W-1:0]    bin_sr_q, bin_sr_d;
  logic [BW-1:0]   bcd_sr_q, bcd_sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // Correct every nibble, then shift {bcd, bin} left as one word.
  logic [BW-1:0]   bcd_fix;
  logic [BW+W-1:0] sh_all;
  logic [BW-1:0]   bcd_sh;
  logic [W-1:0]    bin_sh;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_sr_q[g*BCD_NIB +: BCD_NIB]),
      .dout (bcd_fix[g*BCD_NIB +: BCD_NIB])
    );
  end

  assign sh_all = {bcd_fix, bin_sr_q} << 1;
  assign bcd_sh = sh_all[BW+W-1:W];
  assign bin_sh = sh_all[W-1:0];

`ifdef BIN2BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_nxt;
  logic              zero_run;

  // Walk from the most significant digit down; a digit blanks only while
  // every digit above it is also zero. Digit 0 always shows.
  always_comb begin
    zero_run  = 1'b1;
    blank_nxt = BLANK_NONE[DIGITS-1:0];
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (bcd_sh[i*BCD_NIB +: BCD_NIB] == '0);
      blank_nxt[i] = zero_run;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    bcd_sr_d = bcd_sr_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    done_d   = done_q;
    busy_d   = busy_q;
`ifdef BIN2BCD_LZ_BLANK_EN
    blank_d  = blank_q;
`endif
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          bin_sr_d = num;
          bcd_sr_d = '0;
          cnt_d    = CW'(W);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        bin_sr_d = bin_sh;
        bcd_sr_d = bcd_sh;
        cnt_d    = cnt_q - CW'(1);
        // Last bit: publish the shifted value directly, not the register.
        if (cnt_q == CW'(1)) begin
          bcd_d   = bcd_sh;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef BIN2BCD_LZ_BLANK_EN
          blank_d = blank_nxt;
`endif
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_sr_q <= '0;
      bcd_sr_q <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BIN2BCD_LZ_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      bcd_sr_q <= bcd_sr_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef BIN2BCD_LZ_BLANK_EN
      blank_q  <= blank_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BIN2BCD_LZ_BLANK_EN
  assign blank = blank_q;
`else
  assign blank = BLANK_NONE[DIGITS-1:0];
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (W=8, DIGITS=4). Expected bcd/blank
// come from a decimal golden model and are queued at each accepted start,
// then popped when done is observed.
module tb_bin2bcd_seq;
  localparam int W      = 8;
  localparam int DIGITS = 4;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [W-1:0]          num;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  blank;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .num   (num),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] gold_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] gold_blank(input int v);
    logic [3:0] b;
    b = 4'b0000;
`ifdef BIN2BCD_LZ_BLANK_EN
    if (v < 1000) b[3] = 1'b1;
    if (v < 100)  b[2] = 1'b1;
    if (v < 10)   b[1] = 1'b1;
`endif
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done);
    end
    vectors++;
    if (bcd !== 16'h0000 || blank !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_data bcd=%h blank=%b want 0000 0000", bcd, blank);
    end
    rst = 1'b0;
  endtask

  // One isolated conversion: latency, busy window and result.
  task automatic test_value(input int v, input string tag);
    int   k;
    bit   seen;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; num = W'(v);
    sb.push_back('{gold_bcd(v), gold_blank(v)});
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_accept got %b want 1", tag, busy);
    end
    k = 0; seen = 0;
    while (!seen && k < W + 4) begin
      @(posedge clk); #1;
      k++;
      if (done === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || k != W) begin
      miscompares++;
      $display("FAIL %s latency got %0d (seen=%0d) want %0d", tag, k, seen, W);
    end
    if (seen) begin
      e = sb.pop_front();
      vectors++;
      if (bcd !== e.bcd || blank !== e.blank || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s result bcd=%h blank=%b busy=%b want %h %b 1",
                 tag, bcd, blank, busy, e.bcd, e.blank);
      end
    end else begin
      sb.delete();
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  // Start and num changes while busy must be ignored.
  task automatic test_busy_ignore();
    int   k;
    int   hit;
    int   extra;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; num = W'(37);
    sb.push_back('{gold_bcd(37), gold_blank(37)});
    @(posedge clk); #1;
    start = 1'b0;
    hit = -1; k = 0;
    while (hit < 0 && k < W + 4) begin
      @(posedge clk); #1;
      k++;
      if (k == 3) begin start = 1'b1; num = W'(200); end
      if (k == 4) start = 1'b0;
      if (done === 1'b1) hit = k;
    end
    vectors++;
    if (hit != W) begin
      miscompares++;
      $display("FAIL busy_ignore latency got %0d want %0d", hit, W);
    end
    e = sb.pop_front();
    vectors++;
    if (bcd !== e.bcd || blank !== e.blank) begin
      miscompares++;
      $display("FAIL busy_ignore result bcd=%h blank=%b want %h %b", bcd, blank, e.bcd, e.blank);
    end
    extra = 0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0 || bcd !== e.bcd) begin
      miscompares++;
      $display("FAIL busy_ignore extra_done=%0d bcd=%h want 0 %h", extra, bcd, e.bcd);
    end
  endtask

  // Reset mid-conversion aborts without a done pulse and clears outputs.
  task automatic test_reset_abort();
    int dones;
    @(posedge clk); #1;
    start = 1'b1; num = W'(255);
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bcd !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || blank !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_abort bcd=%h busy=%b done=%b blank=%b want 0000 0 0 0000",
               bcd, busy, done, blank);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || bcd !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_abort_nodone dones=%0d bcd=%h want 0 0000", dones, bcd);
    end
  endtask

  // start tied high: a conversion every W+2 cycles, num sweeps 0..255.
  task automatic test_back_to_back();
    int   hit;
    exp_t e;
    for (int v = 0; v < 256; v++) begin
      num = W'(v);
      start = 1'b1;
      sb.push_back('{gold_bcd(v), gold_blank(v)});
      @(posedge clk); #1;
      hit = -1;
      for (int k = 1; k <= W; k++) begin
        @(posedge clk); #1;
        if (k == 2) num = ~W'(v);
        if (done === 1'b1 && hit < 0) hit = k;
      end
      vectors++;
      if (hit != W) begin
        miscompares++;
        $display("FAIL b2b_timing v=%0d done_at=%0d want %0d", v, hit, W);
      end
      e = sb.pop_front();
      vectors++;
      if (bcd !== e.bcd || blank !== e.blank) begin
        miscompares++;
        $display("FAIL b2b_result v=%0d bcd=%h blank=%b want %h %b", v, bcd, blank, e.bcd, e.blank);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_value(255, "max");
    test_value(0, "zero");
    test_value(100, "hundred");
    test_value(9, "nine");
    test_busy_ignore();
    test_reset_abort();
    test_value(255, "after_abort");
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
